mult8_seq_ctrl: RTL and testbench
=================================

# mult8_seq_ctrl

Sequencing controller that computes an 8x8 unsigned product by time-multiplexing a single 4x4 array multiplier over four nibble passes. It accepts operands over a valid/ready handshake, drives the shared 4x4 multiplier with one nibble pair per cycle, and accumulates the shifted partial products into a 16-bit register. It presents the result over a second valid/ready handshake. The block sits between a requesting engine and the existing `multiplier_4bit_array` datapath, trading latency for area.

## Interface
- `EARLY_ZERO`, default 1: when 1, an operand pair containing a zero operand bypasses the nibble passes.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: controller can accept operands.
- `a` in 8: multiplicand, unsigned.
- `b` in 8: multiplier, unsigned.
- `flush` in 1: synchronous abort; drops any in-flight or held result.
- `out_valid` out 1: `product` valid.
- `out_ready` in 1: consumer accepts `product`.
- `product` out 16: unsigned a*b.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register `a`/`b` into `a_r`/`b_r`, clear `acc`, and set `step`=0.
  - Next state is MUL. If EARLY_ZERO=1 and (`a`==0 || `b`==0), next state is DONE with `acc`=0.
- MUL: a 2-bit `step` selects the nibble pair. The 4x4 product `pp` is zero-extended to 16 bits, shifted, and added to `acc` each cycle.
  - step 0: a_r[3:0] x b_r[3:0], shift 0.
  - step 1: a_r[7:4] x b_r[3:0], shift 4.
  - step 2: a_r[3:0] x b_r[7:4], shift 4.
  - step 3: a_r[7:4] x b_r[7:4], shift 8.
  - After the step-3 accumulate, the next state is DONE.
- DONE:
  - `out_valid`=1 and `product`=`acc`.
  - On `out_ready`, the next state is IDLE.
  - `product` and `out_valid` stay stable while `out_ready`=0.
- Arithmetic:
  - `acc` is 16 bits with no overflow possible; the maximum is 0xFE01.
  - The 4x4 multiplier output is 8 bits and combinational.
  - The adder is a plain 16-bit add.
- `in_ready` is 0 in MUL and DONE. Requests arriving there are not accepted; the requester holds `in_valid`.
- `flush`=1 in any state:
  - Next state is IDLE, `acc` is cleared, and `out_valid` drops at the next edge.
  - `flush` takes priority over `in_valid` and `out_ready` in the same cycle. An IDLE handshake coincident with `flush` is not accepted, because `in_ready` is forced to 0 while `flush`=1.
- Reset (asynchronous, any time including mid-MUL):
  - State IDLE, `step`=0.
  - `acc`, `a_r`, `b_r` = 0.
- Reset values of outputs:
  - `in_ready`=1, `out_valid`=0, `product`=0x0000, `busy`=0.

## Timing
- Accept edge E0. Accumulate edges E1–E4. `out_valid` is high in the cycle after E4, so latency is 5 edges from accept to `out_valid`.
- With the EARLY_ZERO bypass, `out_valid` is high in the cycle after E0, so latency is 1 edge.
- Minimum initiation interval is 6 cycles when `out_ready` is held at 1: 5 cycles in MUL/DONE plus 1 cycle in IDLE for re-acceptance.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`, `out_ready`, `a` or `b` to any output.

## Structure
- Shared package `mult_pkg` holds:
  - the state enum (IDLE/MUL/DONE);
  - constants NIB_W=4, OP_W=8, PROD_W=16;
  - the step-to-shift table (0,4,4,8).
- One sub-module, `multiplier_4bit_array`, is instantiated once and fed by the nibble multiplexers.
- The controller comprises the FSM, step counter, operand registers, nibble multiplexers, shifter and accumulator.

## Test plan
- Reset values: assert `rst_n`=0 → `in_ready`=1, `out_valid`=0, `product`=0x0000, `busy`=0.
- Maximum operands, no backpressure: a=0xFF, b=0xFF, `out_ready`=1 → `product`=0xFE01, `out_valid` high 5 edges after accept for exactly 1 cycle.
- Backpressure: a=0x12, b=0x34, `out_ready` held 0 for 10 cycles → `product`=0x03A8, held stable with `out_valid`=1 and `in_ready`=0 throughout; IDLE follows the `out_ready` edge.
- Zero bypass: a=0x00, b=0xAB with EARLY_ZERO=1 → `product`=0x0000 after 1 edge. With EARLY_ZERO=0, same result after 5 edges.
- Abort: `flush` at step 2 of a=0xA5, b=0x5A → IDLE next edge, `out_valid` never rises. A following a=0x03, b=0x07 → 0x0015.
- Reset mid-operation: `rst_n` low during MUL → outputs reset immediately (asynchronous). Then back-to-back random pairs with random `out_ready` all match a*b against a scoreboard.

Source files
------------

// File: rtl/mult8_seq_ctrl_pkg.sv
// mult_pkg: shared widths, FSM state type and nibble-step shift table
package mult_pkg;
    localparam int NIB_W  = 4;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    // Entry [s] is the left shift applied to the partial product of step s: 0,4,4,8
    localparam logic [3:0][3:0] STEP_SHIFT = {4'd8, 4'd4, 4'd4, 4'd0};
endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// mult8_seq_ctrl_if: operand/result handshakes plus flush and busy status
interface mult8_seq_ctrl_if;
    import mult_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;

    modport master (
        output in_valid, a, b, flush, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, flush, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/multiplier_4bit_array.sv
// multiplier_4bit_array: combinational 4x4 unsigned array multiplier
module multiplier_4bit_array
    import mult_pkg::*;
(
    input  logic [NIB_W-1:0]   x,
    input  logic [NIB_W-1:0]   y,
    output logic [2*NIB_W-1:0] p
);
    // Sum of AND rows, each row shifted by its multiplier bit position
    always_comb begin
        p = '0;
        for (int i = 0; i < NIB_W; i++)
            p = p + ((2*NIB_W)'(y[i] ? x : '0) << i);
    end
endmodule

// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: 8x8 unsigned multiply over four passes of one shared 4x4 multiplier
module mult8_seq_ctrl
    import mult_pkg::*;
#(
    parameter bit EARLY_ZERO = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mult8_seq_ctrl_if.slave bus
);
    state_e              state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [NIB_W-1:0]    nib_a, nib_b;
    logic [2*NIB_W-1:0]  pp;

    // step[0] picks the high nibble of a, step[1] the high nibble of b
    assign nib_a = step_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
    assign nib_b = step_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];

    multiplier_4bit_array u_mul (
        .x (nib_a),
        .y (nib_b),
        .p (pp)
    );

    // Next-state, operand capture and accumulate; flush overrides everything
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        if (bus.flush) begin
            state_d = IDLE;
            step_d  = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = (EARLY_ZERO && (bus.a == '0 || bus.b == '0)) ? DONE : MUL;
                end
                MUL: begin
                    acc_d   = acc_q + (PROD_W'(pp) << STEP_SHIFT[step_q]);
                    step_d  = step_q + 2'd1;
                    state_d = (step_q == 2'd3) ? DONE : MUL;
                end
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Outputs decode from state; flush blocks acceptance in the same cycle
    assign bus.in_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = acc_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb_mult8_seq_ctrl: directed and scoreboarded checks of the sequential 8x8 multiplier
module tb_mult8_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mult8_seq_ctrl_if bus ();
    mult8_seq_ctrl_if bus_z ();

    mult8_seq_ctrl #(.EARLY_ZERO(1'b1)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    mult8_seq_ctrl #(.EARLY_ZERO(1'b0)) dut_z (.clk(clk), .rst_n(rst_n), .bus(bus_z));

    always #5 clk = ~clk;

    // Present an operand pair at a negedge; accepted at the following posedge
    task automatic accept(input logic [7:0] ia, input logic [7:0] ib);
        bus.in_valid = 1'b1;
        bus.a = ia;
        bus.b = ib;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", bus.product); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max();
        bus.out_ready = 1'b1;
        accept(8'hFF, 8'hFF);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (k == 5)) begin errors++; $display("FAIL max_out_valid cycle %0d got %b want %b", k, bus.out_valid, k == 5); end
            if (k == 5) begin
                checks++;
                if (bus.product !== 16'hFE01) begin errors++; $display("FAIL max_product got %h want fe01", bus.product); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bus.out_ready = 1'b0;
        accept(8'h12, 8'h34);
        do begin @(negedge clk); n++; end while (!bus.out_valid && n < 20);
        checks++; if (n != 5) begin errors++; $display("FAIL bp_latency got %0d want 5", n); end
        bus.in_valid = 1'b1;
        bus.a = 8'h55;
        bus.b = 8'h66;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.product !== 16'h03A8 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b p=%h r=%b want v=1 p=03a8 r=0", i, bus.out_valid, bus.product, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got busy=%b r=%b v=%b want 0 1 0", bus.busy, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_zero();
        bus.out_ready = 1'b1;
        bus_z.out_ready = 1'b1;
        bus.in_valid = 1'b1;   bus.a = 8'h00;   bus.b = 8'hAB;
        bus_z.in_valid = 1'b1; bus_z.a = 8'h00; bus_z.b = 8'hAB;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus_z.in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (k == 1)) begin errors++; $display("FAIL zero_bypass_valid cycle %0d got %b want %b", k, bus.out_valid, k == 1); end
            checks++;
            if (bus_z.out_valid !== (k == 5)) begin errors++; $display("FAIL zero_nobypass_valid cycle %0d got %b want %b", k, bus_z.out_valid, k == 5); end
            if (k == 1) begin
                checks++;
                if (bus.product !== 16'h0000) begin errors++; $display("FAIL zero_bypass_product got %h want 0000", bus.product); end
            end
            if (k == 5) begin
                checks++;
                if (bus_z.product !== 16'h0000) begin errors++; $display("FAIL zero_nobypass_product got %h want 0000", bus_z.product); end
            end
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        accept(8'hA5, 8'h5A);
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.product !== 16'h0000) begin
            errors++;
            $display("FAIL flush_abort got busy=%b v=%b p=%h want 0 0 0000", bus.busy, bus.out_valid, bus.product);
        end
        bus.in_valid = 1'b1;
        bus.a = 8'h03;
        bus.b = 8'h07;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept got busy=%b want 0", bus.busy); end
        bus.flush = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (k == 5)) begin errors++; $display("FAIL post_flush_valid cycle %0d got %b want %b", k, bus.out_valid, k == 5); end
        end
        checks++; if (bus.product !== 16'h0015) begin errors++; $display("FAIL post_flush_product got %h want 0015", bus.product); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        accept(8'hC3, 8'h3C);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL mid_reset_product got %h want 0000", bus.product); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        int got = 0;
        int sent = 0;
        int cyc = 0;
        bit acc;
        bus.in_valid = 1'b1;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        while (got < 24 && cyc < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0 || bus.product !== q[0]) begin
                    errors++;
                    $display("FAIL b2b_product #%0d got %h want %h", got, bus.product, q.size() ? q[0] : 16'hxxxx);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                q.push_back(16'(bus.a) * 16'(bus.b));
                sent++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (sent < 24) begin
                    bus.a = (sent % 7 == 3) ? 8'h00 : 8'($urandom);
                    bus.b = 8'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (got != 24) begin errors++; $display("FAIL b2b_count got %0d want 24", got); end
    endtask

    initial begin
        bus.in_valid = 1'b0;   bus.a = '0;   bus.b = '0;   bus.flush = 1'b0;   bus.out_ready = 1'b0;
        bus_z.in_valid = 1'b0; bus_z.a = '0; bus_z.b = '0; bus_z.flush = 1'b0; bus_z.out_ready = 1'b1;
        test_reset();
        test_max();
        test_backpressure();
        test_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
